wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter -- two-requester write-back arbiter feeding a single register-file
// write port through a one-entry commit stage.
//
// Configuration macro: WB_ARB_RR_EN
//   defined   : round-robin between A and B on simultaneous requests, using a
//               1-bit last_grant pointer (A wins the first tie after reset).
//   undefined : fixed priority, A always wins a tie; no pointer is built.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   a_valid/a_reg/a_data       requester A write-back request
//   a_ready                    A's request is accepted this cycle
//   b_valid/b_reg/b_data       requester B write-back request
//   b_ready                    B's request is accepted this cycle
//   hold                       downstream stall, freezes the commit stage
//   RegWrite                   register-file write enable
//   Write_register/Write_data  register-file write index / data
//   Read_register1/2           indices being read from the register file
//   pend1/pend2                staged write targets Read_register1/2
//   fwd_data                   staged write data for forwarding
module wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          hold,
  output logic          RegWrite,
  output logic [AW-1:0] Write_register,
  output logic [DW-1:0] Write_data,
  input  logic [AW-1:0] Read_register1,
  input  logic [AW-1:0] Read_register2,
  output logic          pend1,
  output logic          pend2,
  output logic [DW-1:0] fwd_data
);

  // Commit stage
  logic          out_valid_reg, out_valid_next;
  logic [AW-1:0] out_reg_reg,   out_reg_next;
  logic [DW-1:0] out_data_reg,  out_data_next;

  logic stage_free;
  logic grant_a;
  logic grant_b;
  logic xfer;

  // The stage can take a new entry when empty, or when its current entry
  // is leaving this cycle (valid and not stalled).
  assign stage_free = !out_valid_reg || !hold;

`ifdef WB_ARB_RR_EN
  // last_grant_reg: 1 = B was granted last, so A wins the next tie.
  logic last_grant_reg;

  assign grant_a = a_valid && (!b_valid || last_grant_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
    end else if (xfer) begin
      last_grant_reg <= grant_b;
    end
  end
`else
  assign grant_a = a_valid;
`endif

  assign grant_b = b_valid && !grant_a;

  // Ready is masked by reset so nothing is offered while reset is held.
  assign a_ready = !reset && stage_free && grant_a;
  assign b_ready = !reset && stage_free && grant_b;
  assign xfer    = a_ready || b_ready;

  always_comb begin
    out_valid_next = out_valid_reg;
    out_reg_next   = out_reg_reg;
    out_data_next  = out_data_reg;
    if (stage_free) begin
      out_valid_next = xfer;
      if (a_ready) begin
        out_reg_next  = a_reg;
        out_data_next = a_data;
      end else if (b_ready) begin
        out_reg_next  = b_reg;
        out_data_next = b_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_reg_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_reg_reg   <= out_reg_next;
      out_data_reg  <= out_data_next;
    end
  end

  // Register 0 is hard-wired: writes to it are staged but never performed.
  assign RegWrite       = out_valid_reg && !hold && (out_reg_reg != '0);
  assign Write_register = out_reg_reg;
  assign Write_data     = out_data_reg;
  assign fwd_data       = out_data_reg;

  // Hazard flags, one per read port.
  logic [AW-1:0] rd_idx [2];
  logic [1:0]    pend;

  assign rd_idx[0] = Read_register1;
  assign rd_idx[1] = Read_register2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pend
      assign pend[gi] = out_valid_reg && (out_reg_reg == rd_idx[gi]) && (rd_idx[gi] != '0);
    end
  endgenerate

  assign pend1 = pend[0];
  assign pend2 = pend[1];

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, hold;
  logic [AW-1:0] a_reg, b_reg, Read_register1, Read_register2;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, RegWrite, pend1, pend2;
  logic [AW-1:0] Write_register;
  logic [DW-1:0] Write_data, fwd_data;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .hold(hold),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .Read_register1(Read_register1), .Read_register2(Read_register2),
    .pend1(pend1), .pend2(pend2), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  // Reset with all inputs idle; released 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    a_valid = 0; b_valid = 0; hold = 0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    Read_register1 = '0; Read_register2 = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1; b_valid = 1; hold = 0;
    a_reg = 5'd3; b_reg = 5'd4; a_data = 32'h1; b_data = 32'h2;
    Read_register1 = 5'd3; Read_register2 = 5'd4;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({a_ready, b_ready, RegWrite, pend1, pend2} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ar=%b br=%b rw=%b p1=%b p2=%b, want all 0",
               a_ready, b_ready, RegWrite, pend1, pend2);
    end
    checks++;
    if (Write_register !== '0 || Write_data !== '0) begin
      failures++;
      $display("FAIL reset_stage: got reg=%0d data=%h, want 0/0", Write_register, Write_data);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1; a_reg = 5'd8; a_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got ar=%b br=%b, want 1/0", a_ready, b_ready);
    end
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || Write_register !== 5'd8 || Write_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL single_commit: got rw=%b reg=%0d data=%h, want 1/8/12345678",
               RegWrite, Write_register, Write_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got rw=%b, want 0", RegWrite);
    end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] prev_reg;
    logic exp_a;
    do_reset();
    a_valid = 1; b_valid = 1;
    a_reg = 5'd3; b_reg = 5'd4; a_data = 32'hAAAA_0003; b_data = 32'hBBBB_0004;
    prev_reg = '0;
    for (int k = 0; k < 5; k++) begin
`ifdef WB_ARB_RR_EN
      exp_a = (k % 2) == 0;
`else
      exp_a = 1'b1;
`endif
      @(negedge clk);
      checks++;
      if (a_ready !== exp_a || b_ready !== !exp_a) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got ar=%b br=%b, want %b/%b", k, a_ready, b_ready, exp_a, !exp_a);
      end
      if (k > 0) begin
        checks++;
        if (RegWrite !== 1'b1 || Write_register !== prev_reg) begin
          failures++;
          $display("FAIL rr_commit[%0d]: got rw=%b reg=%0d, want 1/%0d", k, RegWrite, Write_register, prev_reg);
        end
      end
      prev_reg = exp_a ? 5'd3 : 5'd4;
      next_cycle();
    end
    a_valid = 0; b_valid = 0;
  endtask

  task automatic test_hold();
    do_reset();
    a_valid = 1; a_reg = 5'd5; a_data = 32'hCAFE_0005;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_accept: got ar=%b, want 1", a_ready);
    end
    next_cycle();
    a_valid = 0; a_data = 32'hDEAD_DEAD; a_reg = 5'd6;
    b_valid = 1; b_reg = 5'd7; b_data = 32'h7777_7777; hold = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (RegWrite !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 ||
          Write_register !== 5'd5 || Write_data !== 32'hCAFE_0005) begin
        failures++;
        $display("FAIL hold_stall[%0d]: got rw=%b ar=%b br=%b reg=%0d data=%h, want 0/0/0/5/cafe0005",
                 k, RegWrite, a_ready, b_ready, Write_register, Write_data);
      end
      next_cycle();
    end
    hold = 0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || Write_register !== 5'd5 || Write_data !== 32'hCAFE_0005 || b_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: got rw=%b reg=%0d data=%h br=%b, want 1/5/cafe0005/1",
               RegWrite, Write_register, Write_data, b_ready);
    end
    next_cycle();
    b_valid = 0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || Write_register !== 5'd7 || Write_data !== 32'h7777_7777) begin
      failures++;
      $display("FAIL hold_next: got rw=%b reg=%0d data=%h, want 1/7/77777777", RegWrite, Write_register, Write_data);
    end
    next_cycle();
  endtask

  task automatic test_reg0();
    do_reset();
    a_valid = 1; a_reg = 5'd0; a_data = 32'hFFFF_FFFF; Read_register1 = 5'd0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || RegWrite !== 1'b0 || pend1 !== 1'b0) begin
      failures++;
      $display("FAIL reg0_accept: got ar=%b rw=%b p1=%b, want 1/0/0", a_ready, RegWrite, pend1);
    end
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0 || Write_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL reg0_staged: got rw=%b p1=%b p2=%b data=%h, want 0/0/0/ffffffff",
               RegWrite, pend1, pend2, Write_data);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    do_reset();
    a_valid = 1; a_reg = 5'd9; a_data = 32'h0909_ABCD;
    Read_register1 = 5'd7; Read_register2 = 5'd9;
    next_cycle();
    a_valid = 0; hold = 1;
    @(negedge clk);
    checks++;
    if (pend2 !== 1'b1 || pend1 !== 1'b0 || fwd_data !== 32'h0909_ABCD) begin
      failures++;
      $display("FAIL forward: got p1=%b p2=%b fwd=%h, want 0/1/0909abcd", pend1, pend2, fwd_data);
    end
    next_cycle();
    hold = 0;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_valid = 1; a_reg = 5'd9; a_data = 32'h9999_0009; Read_register2 = 5'd9;
    next_cycle();
    a_valid = 0;
    @(negedge clk);
    checks++;
    if (RegWrite !== 1'b1 || pend2 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_before: got rw=%b p2=%b, want 1/1", RegWrite, pend2);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (RegWrite !== 1'b0 || pend2 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got rw=%b p2=%b, want 0/0", RegWrite, pend2);
    end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (RegWrite !== 1'b0 || pend2 !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after[%0d]: got rw=%b p2=%b, want 0/0", k, RegWrite, pend2);
      end
      next_cycle();
    end
  endtask

  // Reference: accepted writes enter a FIFO in grant order and leave it one
  // per non-stalled cycle; the FIFO head is whatever is staged.
  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } wb_t;

  task automatic test_random();
    wb_t q[$];
    wb_t e;
    bit  last_b;
    int  winner;
    bit  free, commit, exp_rw, exp_p1, exp_p2;
    do_reset();
    last_b = 1'b1;
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      b_valid = ($urandom_range(0, 9) < 7);
      a_reg = AW'($urandom_range(0, 7)); b_reg = AW'($urandom_range(0, 7));
      a_data = $urandom; b_data = $urandom;
      hold = ($urandom_range(0, 3) == 0);
      Read_register1 = AW'($urandom_range(0, 7)); Read_register2 = AW'($urandom_range(0, 7));

      free   = (q.size() == 0) || !hold;
      commit = (q.size() != 0) && !hold;
      exp_rw = commit && (q[0].r != 0);
      exp_p1 = (q.size() != 0) && (q[0].r == Read_register1) && (Read_register1 != 0);
      exp_p2 = (q.size() != 0) && (q[0].r == Read_register2) && (Read_register2 != 0);
      if (!free) winner = 0;
      else if (a_valid && b_valid) begin
`ifdef WB_ARB_RR_EN
        winner = last_b ? 1 : 2;
`else
        winner = 1;
`endif
      end
      else if (a_valid) winner = 1;
      else if (b_valid) winner = 2;
      else winner = 0;

      @(negedge clk);
      checks++;
      if (a_ready !== (winner == 1) || b_ready !== (winner == 2)) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got ar=%b br=%b, want %b/%b", c, a_ready, b_ready, winner == 1, winner == 2);
      end
      checks++;
      if (RegWrite !== exp_rw || pend1 !== exp_p1 || pend2 !== exp_p2) begin
        failures++;
        $display("FAIL rand_flags[%0d]: got rw=%b p1=%b p2=%b, want %b/%b/%b",
                 c, RegWrite, pend1, pend2, exp_rw, exp_p1, exp_p2);
      end
      if (q.size() != 0) begin
        checks++;
        if (Write_register !== q[0].r || Write_data !== q[0].d || fwd_data !== q[0].d) begin
          failures++;
          $display("FAIL rand_stage[%0d]: got reg=%0d data=%h fwd=%h, want %0d/%h",
                   c, Write_register, Write_data, fwd_data, q[0].r, q[0].d);
        end
      end

      if (commit) void'(q.pop_front());
      if (winner == 1) begin e.r = a_reg; e.d = a_data; q.push_back(e); last_b = 1'b0; end
      if (winner == 2) begin e.r = b_reg; e.d = b_data; q.push_back(e); last_b = 1'b1; end
      next_cycle();
    end
    a_valid = 0; b_valid = 0; hold = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_hold();
    test_reg0();
    test_forward();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
